// File: rtl/calc_result_display.sv
// ---------------------------------------------------------------------------
// calc_result_display
//
// Captures an 8-bit unsigned magnitude and a sign flag from the calculator.
// A sequential shift-add-3 (double-dabble) engine converts the magnitude to
// three BCD digits. The digits drive a time-multiplexed, active-low, 4-digit
// seven-segment display with sign and leading-zero blanking.
//
// Parameters
//   REFRESH_DIV : clocks per digit slot (>= 2)
//
// Ports
//   i_Clk     in   system clock, rising edge
//   i_Rst_n   in   asynchronous active-low reset
//   i_Result  in   [7:0] magnitude to display
//   i_Neg     in   sign flag, 1 = show minus
//   i_Load    in   capture request, honoured only when idle
//   o_Busy    out  conversion in progress
//   o_Done    out  one-cycle pulse when new digits reach the display registers
//   o_Seg     out  [6:0] segments {g,f,e,d,c,b,a}, active-low
//   o_An      out  [3:0] anodes, active-low one-hot (bit0 ones, bit3 sign)
// ---------------------------------------------------------------------------
module calc_result_display #(
   parameter int REFRESH_DIV = 100000
) (
   input  logic       i_Clk,
   input  logic       i_Rst_n,
   input  logic [7:0] i_Result,
   input  logic       i_Neg,
   input  logic       i_Load,
   output logic       o_Busy,
   output logic       o_Done,
   output logic [6:0] o_Seg,
   output logic [3:0] o_An
);

   localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] CONV = 1'b1;

   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Active-low segment pattern for a BCD digit; non-decimal codes blank.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // Add 3 to every BCD nibble that is 5 or more (the double-dabble correction).
   function automatic logic [11:0] add3(input logic [11:0] b);
      logic [11:0] r;
      for (int i = 0; i < 3; i++) begin
         if (b[i*4 +: 4] >= 4'd5) begin
            r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
         end else begin
            r[i*4 +: 4] = b[i*4 +: 4];
         end
      end
      return r;
   endfunction

   logic [0:0]    state_q, state_d;
   logic [7:0]    shift_q, shift_d;
   logic [11:0]   bcd_q, bcd_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          sign_pend_q, sign_pend_d;
   logic [3:0]    hund_q, hund_d;
   logic [3:0]    tens_q, tens_d;
   logic [3:0]    ones_q, ones_d;
   logic          sign_q, sign_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [CW-1:0] refresh_q, refresh_d;
   logic [1:0]    sel_q, sel_d;
   logic [6:0]    seg_q, seg_d;
   logic [3:0]    an_q, an_d;

   logic [11:0]   bcd_adj;
   logic [11:0]   bcd_next;

   assign bcd_adj  = add3(bcd_q);
   // The shift moves the binary MSB into the BCD LSB.
   assign bcd_next = {bcd_adj[10:0], shift_q[7]};

   // Conversion FSM and display-register update.
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      bcd_d       = bcd_q;
      cnt_d       = cnt_q;
      sign_pend_d = sign_pend_q;
      hund_d      = hund_q;
      tens_d      = tens_q;
      ones_d      = ones_q;
      sign_d      = sign_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_Load) begin
               shift_d     = i_Result;
               sign_pend_d = i_Neg;
               bcd_d       = 12'd0;
               cnt_d       = 4'd0;
               state_d     = CONV;
               busy_d      = 1'b1;
            end else begin
               busy_d = 1'b0;
            end
         end
         CONV: begin
            bcd_d   = bcd_next;
            shift_d = {shift_q[6:0], 1'b0};
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
               hund_d  = bcd_next[11:8];
               tens_d  = bcd_next[7:4];
               ones_d  = bcd_next[3:0];
               sign_d  = sign_pend_q;
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               busy_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // Refresh scan; segment and anode outputs are rebuilt only when the slot changes.
   always_comb begin
      refresh_d = refresh_q;
      sel_d     = sel_q;
      seg_d     = seg_q;
      an_d      = an_q;
      if (refresh_q == CW'(REFRESH_DIV - 1)) begin
         refresh_d = '0;
         sel_d     = sel_q + 2'd1;
         case (sel_d)
            2'd0: begin
               an_d  = 4'b1110;
               seg_d = seg7(ones_q);
            end
            2'd1: begin
               an_d  = 4'b1101;
               seg_d = ((hund_q == 4'd0) && (tens_q == 4'd0)) ? SEG_BLANK : seg7(tens_q);
            end
            2'd2: begin
               an_d  = 4'b1011;
               seg_d = (hund_q == 4'd0) ? SEG_BLANK : seg7(hund_q);
            end
            2'd3: begin
               an_d  = 4'b0111;
               seg_d = sign_q ? SEG_DASH : SEG_BLANK;
            end
            default: begin
               an_d  = 4'b1111;
               seg_d = SEG_BLANK;
            end
         endcase
      end else begin
         refresh_d = refresh_q + CW'(1);
      end
   end

   // State registers.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q     <= IDLE;
         shift_q     <= 8'd0;
         bcd_q       <= 12'd0;
         cnt_q       <= 4'd0;
         sign_pend_q <= 1'b0;
         hund_q      <= 4'd0;
         tens_q      <= 4'd0;
         ones_q      <= 4'd0;
         sign_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         refresh_q   <= '0;
         sel_q       <= 2'd0;
         seg_q       <= 7'b1000000;
         an_q        <= 4'b1110;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         bcd_q       <= bcd_d;
         cnt_q       <= cnt_d;
         sign_pend_q <= sign_pend_d;
         hund_q      <= hund_d;
         tens_q      <= tens_d;
         ones_q      <= ones_d;
         sign_q      <= sign_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         refresh_q   <= refresh_d;
         sel_q       <= sel_d;
         seg_q       <= seg_d;
         an_q        <= an_d;
      end
   end

   assign o_Busy = busy_q;
   assign o_Done = done_q;
   assign o_Seg  = seg_q;
   assign o_An   = an_q;

endmodule
